// File: rtl/pio_m10k_write_ctrl_if.sv
// Bundle between the HPS PIO slaves and the M10K write port.
// The master modport is the write controller; the slave modport is its environment.
interface pio_m10k_write_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 17
);
   logic              pio_valid;
   logic [DATA_W-1:0] pio_data;
   logic              addr_clear;
   logic              m10k_wr_ready;
   logic              pio_ack;
   logic              m10k_wr_en;
   logic [ADDR_W-1:0] m10k_wr_addr;
   logic [DATA_W-1:0] m10k_wr_data;
   logic              frame_done;
   logic              busy;

   modport master (
      input  pio_valid, pio_data, addr_clear, m10k_wr_ready,
      output pio_ack, m10k_wr_en, m10k_wr_addr, m10k_wr_data,
      output frame_done, busy
   );

   modport slave (
      output pio_valid, pio_data, addr_clear, m10k_wr_ready,
      input  pio_ack, m10k_wr_en, m10k_wr_addr, m10k_wr_data,
      input  frame_done, busy
   );
endinterface

// File: rtl/pio_m10k_write_ctrl.sv
// Four-phase valid/ack PIO receiver that streams HPS pixel words
// into the M10K frame buffer at an auto-incrementing, wrapping address.
module pio_m10k_write_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 17,
   parameter int FRAME_WORDS = 76800
) (
   input  logic clk,
   input  logic reset,
   pio_m10k_write_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   state_t state;
   logic   clear_pending;

   assign bus.m10k_wr_en = (state == WRITE) && bus.m10k_wr_ready;
   assign bus.busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         bus.pio_ack      <= 1'b0;
         bus.m10k_wr_addr <= '0;
         bus.m10k_wr_data <= '0;
         bus.frame_done   <= 1'b0;
         clear_pending    <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               // A clear always takes precedence over accepting a word.
               if (bus.addr_clear || clear_pending) begin
                  bus.m10k_wr_addr <= '0;
                  clear_pending    <= 1'b0;
               end else if (bus.pio_valid) begin
                  bus.m10k_wr_data <= bus.pio_data;
                  state            <= WRITE;
               end
            end
            WRITE: begin
               if (bus.addr_clear) clear_pending <= 1'b1;
               if (bus.m10k_wr_ready) begin
                  bus.pio_ack <= 1'b1;
                  state       <= ACK;
                  if (bus.m10k_wr_addr == LAST_ADDR) begin
                     bus.m10k_wr_addr <= '0;
                     bus.frame_done   <= 1'b1;
                  end else begin
                     bus.m10k_wr_addr <= bus.m10k_wr_addr + 1'b1;
                  end
               end
            end
            ACK: begin
               if (bus.addr_clear) clear_pending <= 1'b1;
               if (!bus.pio_valid) begin
                  bus.pio_ack <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_m10k_write_ctrl.sv
// Scoreboard bench for pio_m10k_write_ctrl: every accepted word is
// queued with its expected address and matched against M10K writes.
module tb_pio_m10k_write_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int FW = 12;

   logic clk = 1'b0;
   logic reset;

   pio_m10k_write_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   pio_m10k_write_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .FRAME_WORDS(FW)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int writes   = 0;
   int fd_count = 0;
   int exp_addr = 0;
   bit exp_fd   = 1'b0;
   logic [AW+DW-1:0] sb[$];

   // Write monitor and frame_done model, sampled on the falling edge.
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (bus.frame_done || exp_fd) begin
         checks++;
         if (bus.frame_done !== exp_fd || bus.pio_ack !== 1'b1) begin
            failures++;
            $display("FAIL frame_done: got fd=%0b ack=%0b want fd=%0b ack=1",
                     bus.frame_done, bus.pio_ack, exp_fd);
         end
         if (bus.frame_done) fd_count++;
      end
      exp_fd = 1'b0;
      if (bus.m10k_wr_en === 1'b1) begin
         writes++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: addr=%0d data=%h",
                     bus.m10k_wr_addr, bus.m10k_wr_data);
         end else begin
            e = sb.pop_front();
            if ({bus.m10k_wr_addr, bus.m10k_wr_data} !== e) begin
               failures++;
               $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                        bus.m10k_wr_addr, bus.m10k_wr_data,
                        e[AW+DW-1:DW], e[DW-1:0]);
            end
            if (e[AW+DW-1:DW] == AW'(FW - 1)) exp_fd = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic start_word(input logic [DW-1:0] d);
      bus.pio_data  = d;
      bus.pio_valid = 1'b1;
      sb.push_back({AW'(exp_addr), d});
      exp_addr = (exp_addr == FW - 1) ? 0 : exp_addr + 1;
   endtask

   task automatic finish_word(input int hold);
      int n = 0;
      repeat (hold) tick();
      while (bus.pio_ack !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (bus.pio_ack !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout: ack=%b want 1", bus.pio_ack);
      end
      bus.pio_valid = 1'b0;
      tick();
      chk("ack_fall", 64'(bus.pio_ack), 64'd0);
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      bus.pio_valid     = 1'b0;
      bus.pio_data      = '0;
      bus.addr_clear    = 1'b0;
      bus.m10k_wr_ready = 1'b1;
      #1;
      chk("rst_ack", 64'(bus.pio_ack), 64'd0);
      chk("rst_wr_en", 64'(bus.m10k_wr_en), 64'd0);
      chk("rst_addr", 64'(bus.m10k_wr_addr), 64'd0);
      chk("rst_data", 64'(bus.m10k_wr_data), 64'd0);
      chk("rst_fd", 64'(bus.frame_done), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      start_word(32'hDEADBEEF);
      tick();
      chk("single_wr_en", 64'(bus.m10k_wr_en), 64'd1);
      chk("single_addr", 64'(bus.m10k_wr_addr), 64'd0);
      chk("single_data", 64'(bus.m10k_wr_data), 64'hDEADBEEF);
      tick();
      chk("single_wr_en_off", 64'(bus.m10k_wr_en), 64'd0);
      chk("single_ack", 64'(bus.pio_ack), 64'd1);
      chk("single_addr_inc", 64'(bus.m10k_wr_addr), 64'd1);
      bus.pio_valid = 1'b0;
      tick();
      chk("single_ack_fall", 64'(bus.pio_ack), 64'd0);
      chk("single_idle", 64'(bus.busy), 64'd0);
   endtask

   task automatic test_back_to_back();
      int w0 = writes;
      for (int i = 1; i <= 5; i++) begin
         start_word(DW'(i));
         finish_word(10);
      end
      tick();
      chk("b2b_write_count", 64'(writes - w0), 64'd5);
   endtask

   task automatic test_backpressure();
      bus.m10k_wr_ready = 1'b0;
      start_word(32'hA5A5_0F0F);
      tick();
      for (int i = 0; i < 7; i++) begin
         bus.pio_data = $urandom;
         chk("bp_wr_en", 64'(bus.m10k_wr_en), 64'd0);
         chk("bp_busy", 64'(bus.busy), 64'd1);
         chk("bp_ack", 64'(bus.pio_ack), 64'd0);
         tick();
      end
      bus.m10k_wr_ready = 1'b1;
      #1;
      chk("bp_wr_en_on", 64'(bus.m10k_wr_en), 64'd1);
      chk("bp_data_hold", 64'(bus.m10k_wr_data), 64'hA5A5_0F0F);
      finish_word(0);
   endtask

   task automatic test_frame_wrap();
      int f0 = fd_count;
      for (int i = 0; i < 7; i++) begin
         start_word(32'h100 + DW'(i));
         finish_word(2);
      end
      chk("wrap_fd_pulses", 64'(fd_count - f0), 64'd1);
      chk("wrap_addr", 64'(bus.m10k_wr_addr), 64'(exp_addr));
   endtask

   task automatic test_clear();
      while (exp_addr != 9) begin
         start_word($urandom);
         finish_word(2);
      end
      chk("clr_pre_addr", 64'(bus.m10k_wr_addr), 64'd9);
      start_word(32'hC0DE_0009);
      tick();
      tick();
      bus.addr_clear = 1'b1;
      tick();
      bus.addr_clear = 1'b0;
      finish_word(0);
      exp_addr = 0;
      start_word(32'hC0DE_0000);
      finish_word(2);
      chk("clr_addr_after", 64'(bus.m10k_wr_addr), 64'd1);
      bus.addr_clear = 1'b1;
      exp_addr = 0;
      start_word(32'hC0DE_1000);
      tick();
      bus.addr_clear = 1'b0;
      chk("clr_valid_idle", 64'(bus.busy), 64'd0);
      chk("clr_valid_addr", 64'(bus.m10k_wr_addr), 64'd0);
      finish_word(2);
   endtask

   task automatic test_async_reset();
      chk("ar_pre_addr", 64'(bus.m10k_wr_addr), 64'd1);
      bus.m10k_wr_ready = 1'b0;
      bus.pio_data      = 32'hBAD0_BAD0;
      bus.pio_valid     = 1'b1;
      tick();
      chk("ar_busy", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_wr_en", 64'(bus.m10k_wr_en), 64'd0);
      chk("ar_ack", 64'(bus.pio_ack), 64'd0);
      chk("ar_addr", 64'(bus.m10k_wr_addr), 64'd0);
      chk("ar_fd", 64'(bus.frame_done), 64'd0);
      chk("ar_busy_off", 64'(bus.busy), 64'd0);
      bus.m10k_wr_ready = 1'b1;
      #1;
      chk("ar_wr_en_ready", 64'(bus.m10k_wr_en), 64'd0);
      tick();
      reset    = 1'b0;
      exp_addr = 0;
      sb.push_back({AW'(0), 32'hBAD0_BAD0});
      exp_addr = 1;
      finish_word(2);
      chk("ar_addr_after", 64'(bus.m10k_wr_addr), 64'd1);
   endtask

   initial begin
      test_reset();
      test_single();
      exp_addr = 1;
      test_back_to_back();
      test_backpressure();
      test_frame_wrap();
      test_clear();
      test_async_reset();
      tick();
      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
